// File: rtl/reaction_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reaction_game_ctrl
// Description : Reaction-time game controller. Runs ROUNDS timed rounds per
//               game with a pseudo-random red phase, measures the reaction
//               time in ticks, flags false starts, saturates on timeout and
//               writes per-round scores plus the game's best score to a
//               register file.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_game_ctrl #(
    parameter int          SCORE_W   = 13,
    parameter int          ROUNDS    = 4,
    parameter int          ADDR_W    = 3,
    parameter int          DELAY_W   = 16,
    parameter int          MIN_DELAY = 1000,
    parameter logic [15:0] RAND_MASK = 16'h07FF
) (
    input  logic               Clock,
    input  logic               buttonReset,
    input  logic               buttonStart,
    input  logic               buttonHit,
    input  logic               tick,
    output logic               RedLed,
    output logic               ledGreen,
    output logic               falseStart,
    output logic               done,
    output logic               regWrite,
    output logic [ADDR_W-1:0]  WriteAddress,
    output logic [SCORE_W-1:0] WriteData,
    output logic [SCORE_W-1:0] bestScore,
    output logic [ADDR_W-1:0]  roundIndex,
    output logic [2:0]         State
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_WAIT  = 3'b001,
        S_GO    = 3'b010,
        S_STORE = 3'b011,
        S_FOUL  = 3'b100,
        S_BEST  = 3'b101,
        S_DONE  = 3'b110
    } state_t;

    localparam logic [SCORE_W-1:0] c_SMAX       = {SCORE_W{1'b1}};
    localparam logic [ADDR_W-1:0]  c_LAST_ROUND = ADDR_W'(ROUNDS - 1);
    localparam logic [15:0]        c_LFSR_SEED  = 16'hACE1;

    state_t               r_state;
    logic [15:0]          r_lfsr;
    logic [DELAY_W-1:0]   r_delay;
    logic [SCORE_W-1:0]   r_score;
    logic [SCORE_W-1:0]   r_best;
    logic [ADDR_W-1:0]    r_round;

    logic                 w_lfsr_fb;
    logic [DELAY_W-1:0]   w_load_delay;

    // Taps 16,14,13,11 of a left-shifting Fibonacci LFSR
    assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    // Red-phase length: fixed minimum plus a masked random add-on
    assign w_load_delay = DELAY_W'(MIN_DELAY) + DELAY_W'(r_lfsr & RAND_MASK);

    // Free-running LFSR; advances every cycle so the delay depends on when the player presses
    always_ff @(posedge Clock or negedge buttonReset) begin
        if (!buttonReset) begin
            r_lfsr <= c_LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // Game sequencer: state, delay/score counters, round index and running best
    always_ff @(posedge Clock or negedge buttonReset) begin
        if (!buttonReset) begin
            r_state <= S_IDLE;
            r_delay <= '0;
            r_score <= '0;
            r_best  <= c_SMAX;
            r_round <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (buttonStart) begin
                        r_round <= '0;
                        r_best  <= c_SMAX;
                        r_delay <= w_load_delay;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A hit always wins over the delay expiring in the same cycle
                    if (buttonHit) begin
                        r_state <= S_FOUL;
                    end else if (r_delay == '0) begin
                        r_score <= '0;
                        r_state <= S_GO;
                    end else if (tick) begin
                        r_delay <= r_delay - 1'b1;
                    end
                end
                S_GO: begin
                    // A hit freezes the score before any same-cycle tick increment
                    if (buttonHit || (r_score == c_SMAX)) begin
                        r_state <= S_STORE;
                    end else if (tick) begin
                        r_score <= r_score + 1'b1;
                    end
                end
                S_FOUL: begin
                    r_score <= c_SMAX;
                    r_state <= S_STORE;
                end
                S_STORE: begin
                    if (r_score < r_best) begin
                        r_best <= r_score;
                    end
                    if (r_round == c_LAST_ROUND) begin
                        r_state <= S_BEST;
                    end else begin
                        r_round <= r_round + 1'b1;
                        r_delay <= w_load_delay;
                        r_state <= S_WAIT;
                    end
                end
                S_BEST: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the registered state and counters
    assign RedLed       = (r_state == S_WAIT);
    assign ledGreen     = (r_state == S_GO);
    assign falseStart   = (r_state == S_FOUL);
    assign done         = (r_state == S_DONE);
    assign regWrite     = (r_state == S_STORE) || (r_state == S_BEST);
    // Address 0 holds the best score, rounds occupy addresses 1..ROUNDS
    assign WriteAddress = (r_state == S_STORE) ? (r_round + 1'b1) : '0;
    assign WriteData    = (r_state == S_STORE) ? r_score :
                          (r_state == S_BEST)  ? r_best  : '0;
    assign bestScore    = r_best;
    assign roundIndex   = r_round;
    assign State        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_reaction_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reaction_game_ctrl
// Description : Directed self-checking bench for reaction_game_ctrl with
//               MIN_DELAY=3, RAND_MASK=0, ROUNDS=4 and a tick every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_game_ctrl;

    localparam int SMAX = 8191;

    logic        Clock;
    logic        buttonReset;
    logic        buttonStart;
    logic        buttonHit;
    logic        tick;
    logic        RedLed;
    logic        ledGreen;
    logic        falseStart;
    logic        done;
    logic        regWrite;
    logic [2:0]  WriteAddress;
    logic [12:0] WriteData;
    logic [12:0] bestScore;
    logic [2:0]  roundIndex;
    logic [2:0]  State;

    int tests = 0;
    int fails = 0;

    int wr_addr_q[$];
    int wr_data_q[$];
    int fs_count = 0;

    reaction_game_ctrl #(
        .SCORE_W   (13),
        .ROUNDS    (4),
        .ADDR_W    (3),
        .DELAY_W   (16),
        .MIN_DELAY (3),
        .RAND_MASK (16'h0000)
    ) u_dut (
        .Clock        (Clock),
        .buttonReset  (buttonReset),
        .buttonStart  (buttonStart),
        .buttonHit    (buttonHit),
        .tick         (tick),
        .RedLed       (RedLed),
        .ledGreen     (ledGreen),
        .falseStart   (falseStart),
        .done         (done),
        .regWrite     (regWrite),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .bestScore    (bestScore),
        .roundIndex   (roundIndex),
        .State        (State)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Register-file write log and false-start pulse counter
    always @(negedge Clock) begin
        if (regWrite === 1'b1) begin
            wr_addr_q.push_back(int'(WriteAddress));
            wr_data_q.push_back(int'(WriteData));
        end
        if (falseStart === 1'b1) fs_count++;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output int cyc);
        cyc = 0;
        while (State !== st && cyc < budget) begin
            step(1);
            cyc++;
        end
        if (State !== st) begin
            tests++;
            fails++;
            $display("FAIL wait_state: State=%0d required=%0d after %0d cycles", State, st, cyc);
        end
    endtask

    task automatic do_reset();
        buttonReset = 1'b0;
        buttonStart = 1'b0;
        buttonHit   = 1'b0;
        step(3);
        buttonReset = 1'b1;
        step(1);
        wr_addr_q.delete();
        wr_data_q.delete();
        fs_count = 0;
    endtask

    task automatic pulse_start();
        buttonStart = 1'b1;
        step(1);
        buttonStart = 1'b0;
    endtask

    task automatic pulse_hit();
        buttonHit = 1'b1;
        step(1);
        buttonHit = 1'b0;
    endtask

    // Wait for green, let hit_after ticks elapse, then hit; ends observing STORE
    task automatic play_round(input int hit_after);
        int c;
        wait_state(3'b010, 100, c);
        step(hit_after);
        pulse_hit();
    endtask

    task automatic test_reset();
        buttonReset = 1'b0;
        buttonStart = 1'b0;
        buttonHit   = 1'b0;
        tick        = 1'b1;
        step(3);
        tests++;
        if (State !== 3'b000 || RedLed !== 1'b0 || ledGreen !== 1'b0 || falseStart !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: State=%0d R=%b G=%b F=%b D=%b required 0 0 0 0 0", State, RedLed, ledGreen, falseStart, done);
        end
        tests++;
        if (regWrite !== 1'b0 || WriteAddress !== 3'd0 || WriteData !== 13'd0 || roundIndex !== 3'd0) begin
            fails++;
            $display("FAIL reset_write: we=%b addr=%0d data=%0d round=%0d required 0 0 0 0", regWrite, WriteAddress, WriteData, roundIndex);
        end
        tests++;
        if (bestScore !== 13'd8191) begin
            fails++;
            $display("FAIL reset_best: bestScore=%0d required %0d", bestScore, SMAX);
        end
        buttonReset = 1'b1;
        step(1);
        wr_addr_q.delete();
        wr_data_q.delete();
        // Hit in IDLE is ignored
        pulse_hit();
        step(3);
        tests++;
        if (State !== 3'b000 || wr_addr_q.size() !== 0) begin
            fails++;
            $display("FAIL idle_hit_ignored: State=%0d writes=%0d required 0 0", State, wr_addr_q.size());
        end
    endtask

    task automatic test_first_round();
        int red_cycles;
        int green_cycles;
        do_reset();
        pulse_start();
        // Delay 3 is decremented by three ticks, then the zero is seen for one more cycle
        red_cycles = 0;
        while (RedLed === 1'b1 && red_cycles < 100) begin
            red_cycles++;
            step(1);
        end
        tests++;
        if (red_cycles !== 4 || ledGreen !== 1'b1 || State !== 3'b010) begin
            fails++;
            $display("FAIL red_phase: red_cycles=%0d green=%b State=%0d required 4 1 2", red_cycles, ledGreen, State);
        end
        green_cycles = 0;
        step(5);
        pulse_hit();
        tests++;
        if (regWrite !== 1'b1 || WriteAddress !== 3'd1 || WriteData !== 13'd5) begin
            fails++;
            $display("FAIL first_store: we=%b addr=%0d data=%0d required 1 1 5", regWrite, WriteAddress, WriteData);
        end
        step(1);
        tests++;
        if (roundIndex !== 3'd1 || State !== 3'b001 || regWrite !== 1'b0) begin
            fails++;
            $display("FAIL first_next_round: round=%0d State=%0d we=%b required 1 1 0", roundIndex, State, regWrite);
        end
    endtask

    task automatic test_full_game();
        int exp_a[5] = '{1, 2, 3, 4, 0};
        int exp_d[5] = '{7, 4, 9, 6, 4};
        int hits[4]  = '{7, 4, 9, 6};
        do_reset();
        pulse_start();
        for (int r = 0; r < 4; r++) begin
            play_round(hits[r]);
            step(1);
        end
        // Now observing BEST
        tests++;
        if (regWrite !== 1'b1 || WriteAddress !== 3'd0 || WriteData !== 13'd4 || State !== 3'b101) begin
            fails++;
            $display("FAIL best_write: we=%b addr=%0d data=%0d State=%0d required 1 0 4 5", regWrite, WriteAddress, WriteData, State);
        end
        step(1);
        tests++;
        if (done !== 1'b1 || bestScore !== 13'd4 || roundIndex !== 3'd3) begin
            fails++;
            $display("FAIL game_done: done=%b best=%0d round=%0d required 1 4 3", done, bestScore, roundIndex);
        end
        step(5);
        tests++;
        if (wr_addr_q.size() !== 5 || done !== 1'b1) begin
            fails++;
            $display("FAIL game_write_count: writes=%0d done=%b required 5 1", wr_addr_q.size(), done);
        end
        for (int i = 0; i < 5 && i < wr_addr_q.size(); i++) begin
            tests++;
            if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i]) begin
                fails++;
                $display("FAIL game_write[%0d]: (%0d,%0d) required (%0d,%0d)", i, wr_addr_q[i], wr_data_q[i], exp_a[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_false_start();
        do_reset();
        pulse_start();
        play_round(7);
        step(1);
        // Round 2 red phase: let one tick pass, then hit early
        step(1);
        pulse_hit();
        tests++;
        if (State !== 3'b100 || falseStart !== 1'b1 || RedLed !== 1'b0) begin
            fails++;
            $display("FAIL foul_state: State=%0d falseStart=%b red=%b required 4 1 0", State, falseStart, RedLed);
        end
        step(1);
        tests++;
        if (falseStart !== 1'b0 || regWrite !== 1'b1 || WriteAddress !== 3'd2 || WriteData !== 13'd8191) begin
            fails++;
            $display("FAIL foul_store: fs=%b we=%b addr=%0d data=%0d required 0 1 2 8191", falseStart, regWrite, WriteAddress, WriteData);
        end
        step(1);
        tests++;
        if (roundIndex !== 3'd2 || State !== 3'b001) begin
            fails++;
            $display("FAIL foul_continue: round=%0d State=%0d required 2 1", roundIndex, State);
        end
        play_round(2);
        step(1);
        play_round(3);
        step(2);
        tests++;
        if (done !== 1'b1 || bestScore !== 13'd2 || fs_count !== 1 || wr_addr_q.size() !== 5) begin
            fails++;
            $display("FAIL foul_game_end: done=%b best=%0d fs_pulses=%0d writes=%0d required 1 2 1 5", done, bestScore, fs_count, wr_addr_q.size());
        end
    endtask

    task automatic test_timeout_and_edge_foul();
        int c;
        int green_cycles;
        do_reset();
        pulse_start();
        wait_state(3'b010, 100, c);
        // Score runs 0..8191 in GO, then leaves on saturation
        green_cycles = 0;
        while (ledGreen === 1'b1 && green_cycles < 9000) begin
            green_cycles++;
            step(1);
        end
        tests++;
        if (green_cycles !== 8192 || regWrite !== 1'b1 || WriteAddress !== 3'd1 || WriteData !== 13'd8191) begin
            fails++;
            $display("FAIL timeout_store: green_cycles=%0d we=%b addr=%0d data=%0d required 8192 1 1 8191", green_cycles, regWrite, WriteAddress, WriteData);
        end
        // Hit in the cycle the delay has reached zero
        do_reset();
        pulse_start();
        step(3);
        tests++;
        if (State !== 3'b001) begin
            fails++;
            $display("FAIL edge_still_wait: State=%0d required 1", State);
        end
        pulse_hit();
        tests++;
        if (State !== 3'b100 || falseStart !== 1'b1 || ledGreen !== 1'b0) begin
            fails++;
            $display("FAIL edge_foul: State=%0d fs=%b green=%b required 4 1 0", State, falseStart, ledGreen);
        end
        step(1);
        tests++;
        if (regWrite !== 1'b1 || WriteAddress !== 3'd1 || WriteData !== 13'd8191) begin
            fails++;
            $display("FAIL edge_foul_store: we=%b addr=%0d data=%0d required 1 1 8191", regWrite, WriteAddress, WriteData);
        end
    endtask

    task automatic test_gating_and_midreset();
        int c;
        do_reset();
        pulse_start();
        play_round(2);
        step(1);
        wait_state(3'b010, 100, c);
        pulse_start();
        tests++;
        if (State !== 3'b010 || roundIndex !== 3'd1) begin
            fails++;
            $display("FAIL go_start_ignored: State=%0d round=%0d required 2 1", State, roundIndex);
        end
        step(2);
        pulse_hit();
        tests++;
        if (regWrite !== 1'b1 || WriteAddress !== 3'd2 || WriteData !== 13'd3) begin
            fails++;
            $display("FAIL go_start_store: we=%b addr=%0d data=%0d required 1 2 3", regWrite, WriteAddress, WriteData);
        end
        step(3);
        buttonReset = 1'b0;
        #1;
        tests++;
        if (State !== 3'b000 || roundIndex !== 3'd0 || RedLed !== 1'b0) begin
            fails++;
            $display("FAIL midreset_async: State=%0d round=%0d red=%b required 0 0 0", State, roundIndex, RedLed);
        end
        step(3);
        buttonReset = 1'b1;
        step(20);
        tests++;
        if (wr_addr_q.size() !== 2 || bestScore !== 13'd8191 || State !== 3'b000) begin
            fails++;
            $display("FAIL midreset_after: writes=%0d best=%0d State=%0d required 2 8191 0", wr_addr_q.size(), bestScore, State);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse_start();
        for (int r = 0; r < 4; r++) begin
            play_round(1);
            step(1);
        end
        step(1);
        tests++;
        if (done !== 1'b1 || bestScore !== 13'd1) begin
            fails++;
            $display("FAIL b2b_first_game: done=%b best=%0d required 1 1", done, bestScore);
        end
        pulse_hit();
        tests++;
        if (State !== 3'b110 || regWrite !== 1'b0 || wr_addr_q.size() !== 5) begin
            fails++;
            $display("FAIL done_hit_ignored: State=%0d we=%b writes=%0d required 6 0 5", State, regWrite, wr_addr_q.size());
        end
        pulse_start();
        tests++;
        if (State !== 3'b001 || roundIndex !== 3'd0 || bestScore !== 13'd8191 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_restart: State=%0d round=%0d best=%0d done=%b required 1 0 8191 0", State, roundIndex, bestScore, done);
        end
        play_round(8);
        tests++;
        if (regWrite !== 1'b1 || WriteAddress !== 3'd1 || WriteData !== 13'd8) begin
            fails++;
            $display("FAIL b2b_first_store: we=%b addr=%0d data=%0d required 1 1 8", regWrite, WriteAddress, WriteData);
        end
        step(1);
        tests++;
        if (bestScore !== 13'd8 || roundIndex !== 3'd1) begin
            fails++;
            $display("FAIL b2b_best_update: best=%0d round=%0d required 8 1", bestScore, roundIndex);
        end
    endtask

    initial begin
        tick = 1'b1;
        test_reset();
        test_first_round();
        test_full_game();
        test_false_start();
        test_timeout_and_edge_foul();
        test_gating_and_midreset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
